// File: rtl/nb_dispatch_fsm.sv
// Neighbor dispatch sequencer: streams neighbor-cache entries to the filter one at a time.
// Optional back-pressure cycle counter enabled by defining NB_DISPATCH_STALL_CNT_EN.

package MD_pkg;
   parameter int PARTICLE_ID_WIDTH    = 8;
   parameter int POS_PKT_STRUCT_WIDTH = 48;
endpackage

// state       | meaning
// IDLE        | waiting for i_start
// READ        | read request for current neighbor index on the cache port
// ISSUE       | cache data returning; captured onto the filter outputs
// ARM         | filter flag latency slot
// WAIT_FILTER | hold until filter is idle and not back-pressured
module nb_dispatch_fsm
   import MD_pkg::*;
#(
   parameter int NB_ADDR_WIDTH = 9
)
(
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_start,
   input  logic [PARTICLE_ID_WIDTH-1:0]    i_num_home_particles,
   input  logic [NB_ADDR_WIDTH-1:0]        i_num_nb_particles,
   output logic                            o_nb_rd_en,
   output logic [NB_ADDR_WIDTH-1:0]        o_nb_rd_addr,
   input  logic [POS_PKT_STRUCT_WIDTH-1:0] i_nb_rd_data,
   input  logic                            i_nb_rd_home_flag,
   output logic [PARTICLE_ID_WIDTH-1:0]    o_home_parid,
   output logic [POS_PKT_STRUCT_WIDTH-1:0] o_nb_pos,
   output logic                            o_nb_from_home_cell_flag,
   output logic                            o_nb_valid,
   input  logic                            i_filtering_flag,
   input  logic                            i_back_pressure,
   output logic                            o_busy,
   output logic                            o_done,
   output logic [31:0]                     o_stall_cycles
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      ISSUE,
      ARM,
      WAIT_FILTER
   } state_t;

   state_t                         state;
   logic [PARTICLE_ID_WIDTH-1:0]   home_cnt_q;
   logic [PARTICLE_ID_WIDTH-1:0]   home_wrap;
   logic [NB_ADDR_WIDTH-1:0]       nb_cnt_q;
   logic [NB_ADDR_WIDTH-1:0]       nb_idx;
   logic [NB_ADDR_WIDTH-1:0]       nb_last;

   // A home count of zero behaves like one, so the broadcast ID stays at 0.
   always_comb begin
      home_wrap = '0;
      if (home_cnt_q != '0) begin
         home_wrap = home_cnt_q - PARTICLE_ID_WIDTH'(1);
      end
      nb_last = nb_cnt_q - NB_ADDR_WIDTH'(1);
   end

   // o_home_parid is the home counter itself; it free-runs through back pressure
   // so the filter can re-find its checkpoint ID.
   always_ff @(posedge clk) begin
      if (rst) begin
         state                    <= IDLE;
         home_cnt_q               <= '0;
         nb_cnt_q                 <= '0;
         nb_idx                   <= '0;
         o_nb_rd_en               <= 1'b0;
         o_nb_rd_addr             <= '0;
         o_home_parid             <= '0;
         o_nb_pos                 <= '0;
         o_nb_from_home_cell_flag <= 1'b0;
         o_nb_valid               <= 1'b0;
         o_busy                   <= 1'b0;
         o_done                   <= 1'b0;
      end else begin
         o_nb_rd_en <= 1'b0;
         o_nb_valid <= 1'b0;
         o_done     <= 1'b0;

         if (state != IDLE) begin
            if (o_home_parid >= home_wrap) begin
               o_home_parid <= '0;
            end else begin
               o_home_parid <= o_home_parid + PARTICLE_ID_WIDTH'(1);
            end
         end

         case (state)
            IDLE: begin
               if (i_start) begin
                  home_cnt_q   <= i_num_home_particles;
                  nb_cnt_q     <= i_num_nb_particles;
                  nb_idx       <= '0;
                  o_home_parid <= '0;
                  if (i_num_nb_particles == '0) begin
                     o_done <= 1'b1;
                  end else begin
                     state        <= READ;
                     o_busy       <= 1'b1;
                     o_nb_rd_en   <= 1'b1;
                     o_nb_rd_addr <= '0;
                  end
               end
            end

            READ: begin
               state <= ISSUE;
            end

            ISSUE: begin
               o_nb_pos                 <= i_nb_rd_data;
               o_nb_from_home_cell_flag <= i_nb_rd_home_flag;
               o_nb_valid               <= 1'b1;
               state                    <= ARM;
            end

            ARM: begin
               state <= WAIT_FILTER;
            end

            WAIT_FILTER: begin
               if (!i_filtering_flag && !i_back_pressure) begin
                  if (nb_idx == nb_last) begin
                     o_done       <= 1'b1;
                     o_busy       <= 1'b0;
                     o_home_parid <= '0;
                     state        <= IDLE;
                  end else begin
                     nb_idx       <= nb_idx + NB_ADDR_WIDTH'(1);
                     o_nb_rd_addr <= nb_idx + NB_ADDR_WIDTH'(1);
                     o_nb_rd_en   <= 1'b1;
                     state        <= READ;
                  end
               end
            end

            default: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef NB_DISPATCH_STALL_CNT_EN
   logic [31:0] stall_q;
   logic        start_accept;

   assign start_accept = (state == IDLE) && i_start;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (start_accept) begin
         stall_q <= '0;
      end else if (o_busy && i_back_pressure && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign o_stall_cycles = stall_q;
`else
   assign o_stall_cycles = '0;
`endif

endmodule
